// File: rtl/mnacidpro_valve_seq.sv
// mnacidpro_valve_seq: protocol sequencer for the mnacidpro nucleic-acid chip.
// Steps LOAD -> LYSIS_MIX -> TRAP -> WASH -> ELUTE (per outlet) -> FLUSH -> DONE,
// driving eleven single-valve lines (1 = closed) and a 3-bit peristaltic pump bus.
// Optional macro MNACID_SEQ_PAUSE_EN adds a 'pause' input that freezes all phase
// counters and closes the pump while a run is in LOAD..FLUSH.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      host run control (start sampled only in IDLE)
//   pause             (MNACID_SEQ_PAUSE_EN only) freeze the running phase
//   *_ctrl            valve drives, 1 = closed
//   pump[2:0]         pump valves, 1 = closed
//   collect_sel       one-hot active outlet during ELUTE
//   phase, busy, done, aborted   host status
module mnacidpro_valve_seq #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PUMP_DIV  = 8,
    parameter int unsigned MIX_STEPS = 6,
    parameter int unsigned T_LOAD    = 64,
    parameter int unsigned T_LYSIS   = 64,
    parameter int unsigned T_TRAP    = 64,
    parameter int unsigned T_WASH    = 64,
    parameter int unsigned T_ELUTE   = 64,
    parameter int unsigned T_FLUSH   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
`ifdef MNACID_SEQ_PAUSE_EN
    input  logic            pause,
`endif
    output logic            lysis_ctrl,
    output logic            wash_ctrl,
    output logic            elute_ctrl,
    output logic            dead_end_ctrl,
    output logic            vertical_ctrl,
    output logic            horiz_ctrl,
    output logic            waste_ctrl,
    output logic            bead_ctrl,
    output logic            loop_exit_ctrl,
    output logic            bead_trap_ctrl,
    output logic            collect_ctrl,
    output logic [2:0]      pump,
    output logic [SIZE-1:0] collect_sel,
    output logic [3:0]      phase,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam int unsigned MIX_W = (MIX_STEPS > 1) ? $clog2(MIX_STEPS) : 1;
    localparam int unsigned NV    = 11;

    // Bit positions inside the valve vector
    localparam int unsigned VB_LYSIS = 10, VB_WASH = 9, VB_ELUTE = 8, VB_DEAD = 7,
                            VB_VERT = 6, VB_HORIZ = 5, VB_WASTE = 4, VB_BEAD = 3,
                            VB_LOOP = 2, VB_TRAP = 1, VB_COLLECT = 0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0, S_LOAD  = 4'd1, S_LYSIS = 4'd2, S_TRAP = 4'd3,
        S_WASH  = 4'd4, S_ELUTE = 4'd5, S_FLUSH = 4'd6, S_DONE = 4'd7
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        step_q, step_d;
    logic [MIX_W-1:0]  mixc_q, mixc_d;
    logic              dir_q, dir_d;
    logic [NV-1:0]     valve_q, valve_d;
    logic [2:0]        pump_q, pump_d;
    logic [SIZE-1:0]   sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              active_c, freeze_c, tc_c, entry_c, fwd_c;
    logic [CNT_W-1:0]  t_last_c;

    // Forward pump table; step index 0..5
    function automatic logic [2:0] pump_pat(input logic [2:0] s);
        case (s)
            3'd0:    pump_pat = 3'b011;
            3'd1:    pump_pat = 3'b001;
            3'd2:    pump_pat = 3'b101;
            3'd3:    pump_pat = 3'b100;
            3'd4:    pump_pat = 3'b110;
            default: pump_pat = 3'b010;
        endcase
    endfunction

    // Last timer value of the current phase
    always_comb begin
        case (state_q)
            S_LOAD:  t_last_c = CNT_W'(T_LOAD - 1);
            S_LYSIS: t_last_c = CNT_W'(T_LYSIS - 1);
            S_TRAP:  t_last_c = CNT_W'(T_TRAP - 1);
            S_WASH:  t_last_c = CNT_W'(T_WASH - 1);
            S_ELUTE: t_last_c = CNT_W'(T_ELUTE - 1);
            S_FLUSH: t_last_c = CNT_W'(T_FLUSH - 1);
            default: t_last_c = '0;
        endcase
    end

    assign active_c = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef MNACID_SEQ_PAUSE_EN
    assign freeze_c = active_c && pause;
`else
    assign freeze_c = 1'b0;
`endif
    assign tc_c = (cnt_q == t_last_c) && !freeze_c;

    // Next state, counters and registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = freeze_c ? cnt_q : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        div_d     = div_q;
        step_d    = step_q;
        mixc_d    = mixc_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
        entry_c   = 1'b0;
        fwd_c     = 1'b1;

        // Pump divider; in LYSIS_MIX the direction flips before the move that
        // completes MIX_STEPS patterns in the current direction.
        if (active_c && !freeze_c) begin
            if (div_q == DIV_W'(PUMP_DIV - 1)) begin
                div_d = '0;
                if (state_q == S_LYSIS) begin
                    if (mixc_q == MIX_W'(MIX_STEPS - 1)) begin
                        mixc_d = '0;
                        dir_d  = ~dir_q;
                        fwd_c  = dir_q;
                    end else begin
                        mixc_d = mixc_q + MIX_W'(1);
                        fwd_c  = ~dir_q;
                    end
                end
                if (fwd_c) step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
                else       step_d = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    state_d   = S_LOAD;
                    aborted_d = 1'b0;
                    entry_c   = 1'b1;
                end
            end
            S_LOAD:  if (tc_c) begin state_d = S_LYSIS; entry_c = 1'b1; end
            S_LYSIS: if (tc_c) begin state_d = S_TRAP;  entry_c = 1'b1; end
            S_TRAP:  if (tc_c) begin state_d = S_WASH;  entry_c = 1'b1; end
            S_WASH:  if (tc_c) begin state_d = S_ELUTE; entry_c = 1'b1; end
            S_ELUTE: begin
                // Outlet change restarts only the timer; pump keeps its rhythm
                if (tc_c) begin
                    if (idx_q == IDX_W'(SIZE - 1)) begin
                        state_d = S_FLUSH;
                        entry_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                // An aborted run skips DONE so no done pulse is produced
                if (tc_c) begin
                    state_d = aborted_q ? S_IDLE : S_DONE;
                    entry_c = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                entry_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                entry_c = 1'b1;
            end
        endcase

        if (abort && active_c && (state_q != S_FLUSH)) begin
            state_d   = S_FLUSH;
            aborted_d = 1'b1;
            entry_c   = 1'b1;
        end

        if (entry_c) begin
            cnt_d  = '0;
            idx_d  = '0;
            div_d  = '0;
            step_d = 3'd0;
            mixc_d = '0;
            dir_d  = 1'b0;
        end

        valve_d = '1;
        case (state_d)
            S_LOAD: begin
                valve_d[VB_BEAD] = 1'b0; valve_d[VB_LYSIS] = 1'b0; valve_d[VB_DEAD] = 1'b0;
            end
            S_LYSIS: begin
                valve_d[VB_VERT] = 1'b0; valve_d[VB_HORIZ] = 1'b0;
            end
            S_TRAP: begin
                valve_d[VB_TRAP] = 1'b0; valve_d[VB_LOOP] = 1'b0; valve_d[VB_WASTE] = 1'b0;
            end
            S_WASH: begin
                valve_d[VB_WASH] = 1'b0; valve_d[VB_TRAP] = 1'b0; valve_d[VB_WASTE] = 1'b0;
            end
            S_ELUTE: begin
                valve_d[VB_ELUTE] = 1'b0; valve_d[VB_TRAP] = 1'b0; valve_d[VB_COLLECT] = 1'b0;
            end
            S_FLUSH: begin
                valve_d[VB_WASH] = 1'b0; valve_d[VB_DEAD] = 1'b0; valve_d[VB_VERT] = 1'b0;
                valve_d[VB_HORIZ] = 1'b0; valve_d[VB_LOOP] = 1'b0; valve_d[VB_WASTE] = 1'b0;
            end
            default: valve_d = '1;
        endcase

        if (state_d == S_IDLE || state_d == S_DONE || freeze_c) pump_d = 3'b111;
        else                                                    pump_d = pump_pat(step_d);

        sel_d  = (state_d == S_ELUTE) ? (SIZE'(1) << idx_d) : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            step_q    <= 3'd0;
            mixc_q    <= '0;
            dir_q     <= 1'b0;
            valve_q   <= '1;
            pump_q    <= 3'b111;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            step_q    <= step_d;
            mixc_q    <= mixc_d;
            dir_q     <= dir_d;
            valve_q   <= valve_d;
            pump_q    <= pump_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign lysis_ctrl     = valve_q[VB_LYSIS];
    assign wash_ctrl      = valve_q[VB_WASH];
    assign elute_ctrl     = valve_q[VB_ELUTE];
    assign dead_end_ctrl  = valve_q[VB_DEAD];
    assign vertical_ctrl  = valve_q[VB_VERT];
    assign horiz_ctrl     = valve_q[VB_HORIZ];
    assign waste_ctrl     = valve_q[VB_WASTE];
    assign bead_ctrl      = valve_q[VB_BEAD];
    assign loop_exit_ctrl = valve_q[VB_LOOP];
    assign bead_trap_ctrl = valve_q[VB_TRAP];
    assign collect_ctrl   = valve_q[VB_COLLECT];
    assign pump           = pump_q;
    assign collect_sel    = sel_q;
    assign phase          = 4'(state_q);
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// Self-checking bench for mnacidpro_valve_seq: directed tables for the pump
// patterns, hand sequences for run length / abort / reset, then random
// start/abort (and pause when MNACID_SEQ_PAUSE_EN is defined) against a
// schedule-queue reference model.
module tb_mnacidpro_valve_seq;

    localparam int unsigned SIZE = 4, CNT_W = 8, PUMP_DIV = 2, MIX_STEPS = 2;
    localparam int unsigned T_LOAD = 12, T_LYSIS = 8, T_TRAP = 5, T_WASH = 6,
                            T_ELUTE = 4, T_FLUSH = 4;
    localparam int unsigned RUN_LEN = T_LOAD + T_LYSIS + T_TRAP + T_WASH
                                    + SIZE * T_ELUTE + T_FLUSH + 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
    logic waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
    logic [2:0] pump;
    logic [SIZE-1:0] collect_sel;
    logic [3:0] phase;
    logic busy, done, aborted;

    always #5 clk = ~clk;

    mnacidpro_valve_seq #(
        .SIZE(SIZE), .CNT_W(CNT_W), .PUMP_DIV(PUMP_DIV), .MIX_STEPS(MIX_STEPS),
        .T_LOAD(T_LOAD), .T_LYSIS(T_LYSIS), .T_TRAP(T_TRAP), .T_WASH(T_WASH),
        .T_ELUTE(T_ELUTE), .T_FLUSH(T_FLUSH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef MNACID_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
        .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl),
        .horiz_ctrl(horiz_ctrl), .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl),
        .loop_exit_ctrl(loop_exit_ctrl), .bead_trap_ctrl(bead_trap_ctrl),
        .collect_ctrl(collect_ctrl), .pump(pump), .collect_sel(collect_sel),
        .phase(phase), .busy(busy), .done(done), .aborted(aborted)
    );

    int n_checks = 0, n_err = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: queue of (phase, cycle-in-phase) ------
    typedef struct { logic [3:0] ph; int k; } rec_t;
    rec_t sched[$];
    rec_t cur = '{ph: 4'd0, k: 0};
    bit   m_aborted = 1'b0, m_paused = 1'b0;
    logic [2:0] pats [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    function automatic void push_phase(input logic [3:0] ph, input int n);
        for (int k = 0; k < n; k++) sched.push_back('{ph: ph, k: k});
    endfunction

    function automatic logic [2:0] exp_pump(input logic [3:0] ph, input int k);
        int s, pos;
        if (ph == 4'd0 || ph == 4'd7) return 3'b111;
        s = k / PUMP_DIV;
        pos = 0;
        if (ph == 4'd2) begin
            // step j (1-based pattern number) runs reverse in odd MIX_STEPS blocks
            for (int j = 1; j <= s; j++)
                pos = (((j / MIX_STEPS) % 2) == 1) ? (pos + 5) % 6 : (pos + 1) % 6;
        end else begin
            pos = s % 6;
        end
        return pats[pos];
    endfunction

    // closed-valve vector {lysis,wash,elute,dead,vert,horiz,waste,bead,loop,trap,collect}
    function automatic logic [10:0] exp_valves(input logic [3:0] ph);
        logic [10:0] v;
        v = 11'h7FF;
        case (ph)
            4'd1: begin v[3] = 0; v[10] = 0; v[7] = 0; end
            4'd2: begin v[6] = 0; v[5] = 0; end
            4'd3: begin v[1] = 0; v[2] = 0; v[4] = 0; end
            4'd4: begin v[9] = 0; v[1] = 0; v[4] = 0; end
            4'd5: begin v[8] = 0; v[1] = 0; v[0] = 0; end
            4'd6: begin v[9] = 0; v[7] = 0; v[6] = 0; v[5] = 0; v[2] = 0; v[4] = 0; end
            default: v = 11'h7FF;
        endcase
        return v;
    endfunction

    function automatic void model_edge();
        bool_run: begin end
        m_paused = pause && (cur.ph >= 4'd1) && (cur.ph <= 4'd6);
        if (rst) begin
            sched.delete();
            cur = '{ph: 4'd0, k: 0};
            m_aborted = 1'b0;
            m_paused  = 1'b0;
        end else if (cur.ph == 4'd0) begin
            if (start && !abort) begin
                m_aborted = 1'b0;
                push_phase(4'd1, T_LOAD);  push_phase(4'd2, T_LYSIS);
                push_phase(4'd3, T_TRAP);  push_phase(4'd4, T_WASH);
                push_phase(4'd5, SIZE * T_ELUTE);
                push_phase(4'd6, T_FLUSH); push_phase(4'd7, 1);
                cur = sched.pop_front();
            end
        end else if (abort && cur.ph >= 4'd1 && cur.ph <= 4'd5) begin
            m_aborted = 1'b1;
            sched.delete();
            push_phase(4'd6, T_FLUSH);
            cur = sched.pop_front();
        end else if (m_paused) begin
            // hold current record
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else begin
            cur = '{ph: 4'd0, k: 0};
        end
    endfunction

    task automatic compare_all();
        logic [10:0] v;
        logic [SIZE-1:0] sel;
        v = {lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl,
             waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl};
        sel = (cur.ph == 4'd5) ? SIZE'(1) << (cur.k / T_ELUTE) : '0;
        check("phase", 32'(phase), 32'(cur.ph));
        check("pump", 32'(pump), 32'(m_paused ? 3'b111 : exp_pump(cur.ph, cur.k)));
        check("valves", 32'(v), 32'(exp_valves(cur.ph)));
        check("collect_sel", 32'(collect_sel), 32'(sel));
        check("busy_done_aborted", 32'({busy, done, aborted}),
              32'({cur.ph != 4'd0, cur.ph == 4'd7, m_aborted}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    // ---------------- directed pump table -------------------------------------
    typedef struct { logic st; logic [3:0] ph; logic [2:0] pmp; } vec_t;
    vec_t tbl [20];

    initial begin
        int n, done_at, bound;
        bit saw_done;

        for (int i = 0; i < 20; i++) tbl[i].st = (i == 0);
        tbl[0].pmp  = 3'b011; tbl[1].pmp  = 3'b011; tbl[2].pmp  = 3'b001; tbl[3].pmp  = 3'b001;
        tbl[4].pmp  = 3'b101; tbl[5].pmp  = 3'b101; tbl[6].pmp  = 3'b100; tbl[7].pmp  = 3'b100;
        tbl[8].pmp  = 3'b110; tbl[9].pmp  = 3'b110; tbl[10].pmp = 3'b010; tbl[11].pmp = 3'b010;
        tbl[12].pmp = 3'b011; tbl[13].pmp = 3'b011; tbl[14].pmp = 3'b001; tbl[15].pmp = 3'b001;
        tbl[16].pmp = 3'b011; tbl[17].pmp = 3'b011; tbl[18].pmp = 3'b010; tbl[19].pmp = 3'b010;
        for (int i = 0; i < 20; i++) tbl[i].ph = (i < 12) ? 4'd1 : 4'd2;

        // reset, then 100 idle cycles
        step(); step();
        check("reset_pump", 32'(pump), 32'(3'b111));
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (100) step();

        // table: LOAD and LYSIS_MIX pump patterns
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].st;
            step();
            check("tbl_phase", 32'(phase), 32'(tbl[i].ph));
            check("tbl_pump", 32'(pump), 32'(tbl[i].pmp));
        end
        start = 1'b0;

        // rest of the run: total busy length and done position
        n = 20; done_at = 0; bound = 0;
        while (busy && bound < 200) begin
            step(); bound++;
            if (busy) n++;
            if (done) done_at = n;
        end
        check("busy_len", 32'(n), 32'(RUN_LEN));
        check("done_at", 32'(done_at), 32'(RUN_LEN));
        step();
        check("idle_after_run", 32'(phase), 32'd0);

        // abort in WASH second cycle
        start = 1'b1; step(); start = 1'b0;
        bound = 0;
        while (phase != 4'd4 && bound < 200) begin step(); bound++; end
        check("reach_wash", 32'(phase), 32'd4);
        step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_phase", 32'(phase), 32'd6);
        check("abort_flag", 32'(aborted), 32'd1);
        n = 1; saw_done = 1'b0; bound = 0;
        while (phase == 4'd6 && bound < 200) begin
            step(); bound++;
            if (phase == 4'd6) n++;
            if (done) saw_done = 1'b1;
        end
        check("abort_flush_len", 32'(n), 32'(T_FLUSH));
        check("abort_to_idle", 32'(phase), 32'd0);
        check("abort_no_done", 32'(saw_done), 32'd0);
        abort = 1'b1; repeat (3) step(); abort = 1'b0;
        check("abort_idle_sticky", 32'(aborted), 32'd1);

        // start + abort together in IDLE
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);

        // later start clears aborted
        start = 1'b1; step(); start = 1'b0;
        check("start_clears_aborted", 32'(aborted), 32'd0);

        // reset mid-run
        repeat (10) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midrun_reset_phase", 32'(phase), 32'd0);
        check("midrun_reset_pump", 32'(pump), 32'(3'b111));

`ifdef MNACID_SEQ_PAUSE_EN
        // pause 10 cycles mid-TRAP
        start = 1'b1; step(); start = 1'b0;
        bound = 0;
        while (phase != 4'd3 && bound < 200) begin step(); bound++; end
        check("reach_trap", 32'(phase), 32'd3);
        n = 1; step(); n++;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); n++;
            check("pause_pump", 32'(pump), 32'(3'b111));
        end
        pause = 1'b0;
        bound = 0;
        while (phase == 4'd3 && bound < 200) begin
            step(); bound++;
            if (phase == 4'd3) n++;
        end
        check("pause_trap_len", 32'(n), 32'(T_TRAP + 10));
        bound = 0;
        while (busy && bound < 200) begin step(); bound++; end
`endif

        // random start/abort/pause against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 59) == 0);
`ifdef MNACID_SEQ_PAUSE_EN
            if ($urandom_range(0, 15) == 0) pause = ~pause;
`endif
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mnacidpro_valve_seq.md
Name: mnacidpro_valve_seq

Overview:
- Digital protocol sequencer directly upstream of the mnacidpro nucleic-acid processing chip.
- Drives all eleven single-valve control lines and the 3-bit peristaltic pump control bus.
- Steps through a fixed protocol: load → lysis mix → bead trap → wash → per-outlet elute → flush.
- Elution is sequenced across SIZE collect outlets; status is reported to a host controller.

Parameters:
- SIZE, 4, number of collect outlets (must match chip SIZE); range 1..16.
- CNT_W, 16, width of the phase timer.
- PUMP_DIV, 8, clock cycles per pump pattern step; must be ≥1.
- MIX_STEPS, 6, pump steps per direction reversal during LYSIS_MIX; must be ≥1.
- T_LOAD, T_LYSIS, T_TRAP, T_WASH, T_ELUTE, T_FLUSH, 64 each, phase durations in clock cycles; each must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin protocol; sampled only in IDLE
- abort  in  1  terminate run via FLUSH
- lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl, waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl  out  1 each  valve drive; 1 = closed, 0 = open
- pump  out  3  peristaltic pump valves; 1 = closed
- collect_sel  out  SIZE  one-hot active outlet; zero outside ELUTE
- phase  out  4  current state encoding
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset: all 11 valves = 1, pump = 3'b111, collect_sel = 0, phase = IDLE, busy = 0, done = 0, aborted = 0.
- Reset asserted mid-run returns the block to these values on the next clock edge.
- State encodings: IDLE=0, LOAD=1, LYSIS_MIX=2, TRAP=3, WASH=4, ELUTE=5, FLUSH=6, DONE=7.
- All outputs are registered, so they reflect the new state in the same cycle phase changes.
- Phase timer:
  - Clears to 0 on state entry and increments each cycle.
  - A phase of duration T exits when timer == T-1, so the phase lasts exactly T cycles.
- Transitions:
  - IDLE → LOAD on start. start is ignored while busy.
  - LOAD → LYSIS_MIX → TRAP → WASH → ELUTE.
  - ELUTE lasts T_ELUTE cycles per outlet, with idx running 0..SIZE-1. At the end of each T_ELUTE, idx < SIZE-1 increments idx and stays in ELUTE (timer cleared); idx == SIZE-1 goes to FLUSH.
  - FLUSH → DONE → IDLE. DONE lasts 1 cycle and asserts done.
- Open valves per state (every valve not listed is closed, i.e. 1):
  - IDLE, DONE: none open; pump 111.
  - LOAD: bead, lysis, dead_end.
  - LYSIS_MIX: vertical, horiz.
  - TRAP: bead_trap, loop_exit, waste.
  - WASH: wash, bead_trap, waste.
  - ELUTE: elute, bead_trap, collect; collect_sel = 1<<idx.
  - FLUSH: wash, dead_end, vertical, horiz, loop_exit, waste.
- Pump:
  - Forward cycle: 011, 001, 101, 100, 110, 010, then wraps to 011.
  - Step index advances once every PUMP_DIV cycles while in LOAD..FLUSH, and resets to 0 with the divider on each state entry.
  - The pattern is active from the first cycle of the state.
  - In LYSIS_MIX, direction toggles after every MIX_STEPS steps; the first direction is forward, reverse walks the same table backwards with wrap-around.
  - All other active states pump forward only.
- abort:
  - In LOAD..ELUTE: next state FLUSH, aborted ← 1. FLUSH then completes normally to IDLE, but done is not pulsed.
  - abort during FLUSH or DONE: ignored.
  - abort in IDLE: no effect.
  - start and abort together in IDLE: abort wins, block stays IDLE.
- The timer does not overflow because each T fits in CNT_W. A value of T ≥ 2^CNT_W is a configuration error.

Optional Feature:
- Macro: MNACID_SEQ_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause = 1 and the state is in LOAD..FLUSH: timer, pump divider, pump step and mix direction all freeze, and pump is forced to 111. Valves hold their state pattern.
  - Release resumes exactly from the frozen counts.
  - abort still takes effect while paused.
- When undefined:
  - No pause port; the block runs uninterrupted.

Test Plan:
- Reset then idle: rst for 2 cycles → all ctrl = 1, pump = 111, busy = 0. With start held low for 100 cycles, outputs are unchanged.
- Full run, parameters T_* = 4, SIZE = 4, PUMP_DIV = 1: start pulse → phase sequence 1,2,3,4,5,6,7,0. Total busy duration = 4·4 + 4·4 + 4 + 1 = 37 cycles. done high exactly at cycle 37 of busy. collect_sel steps 0001, 0010, 0100, 1000, each held 4 cycles.
- Pump pattern, LOAD with PUMP_DIV = 2, T_LOAD = 12 → pump = 011,011,001,001,101,101,100,100,110,110,010,010.
- Mix reversal, PUMP_DIV = 1, MIX_STEPS = 2, T_LYSIS = 8 → pump = 011,001,011,010,011,001,011,010.
- Abort in WASH cycle 2 → next cycle phase = 6, aborted = 1, FLUSH lasts T_FLUSH, then IDLE with no done pulse. A later start clears aborted.
- With MNACID_SEQ_PAUSE_EN, pause for 10 cycles mid-TRAP → pump = 111 and the phase is extended by exactly 10 cycles. Simultaneous start + abort in IDLE → busy stays 0.
